// File: rtl/i2c_temp_sensor_target.sv
// I2C target emulating the ADT7420 register interface; the temperature comes from a port.
// Optional I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample stability filter after the synchronisers.
module i2c_temp_sensor_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h48,
  parameter logic [7:0] DEVICE_ID   = 8'hCB,
  parameter logic [7:0] CONFIG_RST  = 8'h00
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] temp_value,
  output logic [7:0]  config_reg,
  output logic        busy,
  output logic        addr_hit,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StAddr     = 4'd1,
    StAddrAck  = 4'd2,
    StWrPtr    = 4'd3,
    StWrData   = 4'd4,
    StWrAck    = 4'd5,
    StRdData   = 4'd6,
    StRdAck    = 4'd7,
    StWaitStop = 4'd8
  } state_e;

  // Synchronisers reset to the idle-high bus level so reset release is not seen as a START.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_s, sda_s, scl_f, sda_f;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_s};
      sda_hist_q <= {sda_hist_q[0], sda_s};
      if (scl_s == scl_hist_q[0] && scl_s == scl_hist_q[1]) scl_filt_q <= scl_s;
      if (sda_s == sda_hist_q[0] && sda_s == sda_hist_q[1]) sda_filt_q <= sda_s;
    end
  end

  assign scl_f = scl_filt_q;
  assign sda_f = sda_filt_q;
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

  function automatic logic [7:0] reg_byte(input logic [7:0]  ptr,
                                          input logic [15:0] snap,
                                          input logic [7:0]  cfg);
    case (ptr)
      8'h00:   return snap[15:8];
      8'h01:   return snap[7:0];
      8'h02:   return 8'h00;
      8'h03:   return cfg;
      8'h0B:   return DEVICE_ID;
      default: return 8'h00;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  pointer_q, pointer_d;
  logic [7:0]  config_q, config_d;
  logic [15:0] snapshot_q, snapshot_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        addr_hit_q, addr_hit_d;
  logic [7:0]  rx_byte;
  logic [7:0]  ptr_inc;

  assign rx_byte = {shift_q, sda_f};
  assign ptr_inc = pointer_q + 8'd1;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      pointer_q  <= 8'h00;
      config_q   <= CONFIG_RST;
      snapshot_q <= 16'h0000;
      tx_q       <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      addr_hit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pointer_q  <= pointer_d;
      config_q   <= config_d;
      snapshot_q <= snapshot_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      addr_hit_q <= addr_hit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pointer_d  = pointer_q;
    config_d   = config_q;
    snapshot_d = snapshot_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    addr_hit_d = 1'b0;

    if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          sda_oe_d = 1'b0;
        end
        StAddr: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == TARGET_ADDR) begin
                addr_hit_d = 1'b1;
                busy_d     = 1'b1;
                rw_d       = rx_byte[0];
                state_d    = StAddrAck;
                if (rx_byte[0]) snapshot_d = temp_value;
              end else begin
                state_d = StWaitStop;
              end
            end
          end
        end
        // ACK states: pull SDA on the fall after bit 8, move on at the 9th rise.
        StAddrAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b1;
          end else if (scl_rise) begin
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              tx_d    = reg_byte(pointer_q, snapshot_q, config_q);
              state_d = StRdData;
            end else begin
              state_d = StWrPtr;
            end
          end
        end
        StWrPtr, StWrData: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == StWrPtr) begin
                pointer_d = rx_byte;
              end else begin
                if (pointer_q == 8'h03) config_d = rx_byte;
                pointer_d = ptr_inc;
              end
              state_d = StWrAck;
            end
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b1;
          end else if (scl_rise) begin
            bit_cnt_d = 3'd0;
            state_d   = StWrData;
          end
        end
        StRdData: begin
          if (scl_fall) begin
            sda_oe_d = ~tx_q[3'd7 - bit_cnt_q];
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = StRdAck;
          end
        end
        StRdAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            bit_cnt_d = 3'd0;
            if (!sda_f) begin
              pointer_d = ptr_inc;
              tx_d      = reg_byte(ptr_inc, snapshot_q, config_q);
              state_d   = StRdData;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StWaitStop: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe     = sda_oe_q;
  assign config_reg = config_q;
  assign busy       = busy_q;
  assign addr_hit   = addr_hit_q;
  assign State      = state_q;

endmodule

// File: tb/tb_i2c_temp_sensor_target.sv
// Self-checking bench: a behavioural I2C master on a wired-AND SDA line, with expected
// bytes and ACK bits queued as stimulus is driven and popped when the response arrives.
module tb_i2c_temp_sensor_target;

  localparam int Q = 60;   // quarter SCL period (6 sys_clk cycles)
  localparam int H = 120;  // SCL high time

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] temp_value = 16'h0000;
  logic        sda_oe;
  logic [7:0]  config_reg;
  logic        busy;
  logic        addr_hit;
  logic [3:0]  state;
  logic        sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_temp_sensor_target dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .scl_in     (scl),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .temp_value (temp_value),
    .config_reg (config_reg),
    .busy       (busy),
    .addr_hit   (addr_hit),
    .State      (state)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;
  int hit_cnt  = 0;
  int oe_cnt   = 0;

  logic [7:0] exp_q[$];
  logic       ack_q[$];

  always @(posedge sys_clk) begin
    if (addr_hit) hit_cnt <= hit_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic i2c_start();
    sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q; scl = 1'b1; #H; scl = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; #Q; scl = 1'b1; #(H - 10); b = sda_line; #10; scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(master_ack);
  endtask

  // Sends a byte and compares the target's ACK bit against the queued expectation.
  task automatic send_checked(input logic [7:0] d, input logic exp_ack);
    logic ack, exp;
    ack_q.push_back(exp_ack);
    send_byte(d, ack);
    exp = ack_q.pop_front();
    n_checks++;
    if (ack !== exp) begin
      n_errors++;
      $display("FAIL ack_after_%h: got %b expected %b", d, ack, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    n_checks++;
    if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (addr_hit !== 1'b0) begin n_errors++; $display("FAIL reset_addr_hit: got %b expected 0", addr_hit); end
    n_checks++;
    if (state !== 4'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++;
    if (config_reg !== 8'h00) begin n_errors++; $display("FAIL reset_config: got %h expected 00", config_reg); end
  endtask

  task automatic test_ptr_write_read();
    logic [7:0] got, exp;
    int hits0;
    hits0 = hit_cnt;
    temp_value = 16'h0C80;
    i2c_start();
    send_checked(8'h90, 1'b0);
    send_checked(8'h00, 1'b0);
    i2c_rstart();
    send_checked(8'h91, 1'b0);
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'h80);
    recv_byte(1'b0, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL ptr_read_msb: got %h expected %h", got, exp); end
    recv_byte(1'b1, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL ptr_read_lsb: got %h expected %h", got, exp); end
    i2c_stop();
    repeat (4) @(negedge sys_clk);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL ptr_busy_after_stop: got %b expected 0", busy); end
    n_checks++;
    if (hit_cnt - hits0 != 2) begin
      n_errors++; $display("FAIL ptr_addr_hits: got %0d expected 2", hit_cnt - hits0);
    end
  endtask

  task automatic test_addr_mismatch();
    int hits0, oe0;
    hits0 = hit_cnt;
    oe0 = oe_cnt;
    i2c_start();
    send_checked(8'h92, 1'b1);
    send_checked(8'h5A, 1'b1);
    send_checked(8'hA5, 1'b1);
    i2c_stop();
    repeat (4) @(negedge sys_clk);
    n_checks++;
    if (oe_cnt != oe0) begin n_errors++; $display("FAIL mismatch_sda_oe_cycles: got %0d expected 0", oe_cnt - oe0); end
    n_checks++;
    if (hit_cnt != hits0) begin n_errors++; $display("FAIL mismatch_addr_hit: got %0d expected 0", hit_cnt - hits0); end
    n_checks++;
    if (state !== 4'd0) begin n_errors++; $display("FAIL mismatch_state: got %0d expected 0", state); end
  endtask

  task automatic test_config_id();
    logic [7:0] got, exp;
    i2c_start();
    send_checked(8'h90, 1'b0);
    send_checked(8'h03, 1'b0);
    send_checked(8'hA5, 1'b0);
    i2c_stop();
    repeat (4) @(negedge sys_clk);
    n_checks++;
    if (config_reg !== 8'hA5) begin n_errors++; $display("FAIL config_write: got %h expected a5", config_reg); end
    i2c_start();
    send_checked(8'h90, 1'b0);
    send_checked(8'h0B, 1'b0);
    i2c_rstart();
    send_checked(8'h91, 1'b0);
    exp_q.push_back(8'hCB);
    recv_byte(1'b1, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL device_id: got %h expected %h", got, exp); end
    i2c_stop();
  endtask

  task automatic test_snapshot();
    logic [7:0] got, exp;
    temp_value = 16'h1234;
    i2c_start();
    send_checked(8'h90, 1'b0);
    send_checked(8'h00, 1'b0);
    i2c_rstart();
    send_checked(8'h91, 1'b0);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    recv_byte(1'b0, got);
    temp_value = 16'h5678;
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL snapshot_msb: got %h expected %h", got, exp); end
    recv_byte(1'b1, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL snapshot_lsb: got %h expected %h", got, exp); end
    i2c_stop();
  endtask

  task automatic test_pointer_wrap();
    logic [7:0] got, exp;
    temp_value = 16'hABCD;
    i2c_start();
    send_checked(8'h90, 1'b0);
    send_checked(8'hFF, 1'b0);
    i2c_rstart();
    send_checked(8'h91, 1'b0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hAB);
    recv_byte(1'b0, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL wrap_reg_ff: got %h expected %h", got, exp); end
    recv_byte(1'b1, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL wrap_reg_00: got %h expected %h", got, exp); end
    i2c_stop();
  endtask

  task automatic test_abort_reset();
    logic       b;
    logic [7:0] got, exp;
    temp_value = 16'h5500;
    i2c_start();
    send_checked(8'h90, 1'b0);
    send_checked(8'h01, 1'b0);
    i2c_rstart();
    send_checked(8'h91, 1'b0);
    for (int i = 0; i < 3; i++) recv_bit(b);
    for (int i = 0; i < 50 && sda_oe !== 1'b1; i++) @(negedge sys_clk);
    n_checks++;
    if (sda_oe !== 1'b1) begin n_errors++; $display("FAIL abort_pre_sda_oe: got %b expected 1", sda_oe); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL abort_async_sda_oe: got %b expected 0", sda_oe); end
    n_checks++;
    if (state !== 4'd0) begin n_errors++; $display("FAIL abort_state: got %0d expected 0", state); end
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if (config_reg !== 8'h00) begin n_errors++; $display("FAIL abort_config: got %h expected 00", config_reg); end
    reset_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    i2c_stop();
    // Pointer was 01 before reset; a read without a pointer write must come from 00.
    i2c_start();
    send_checked(8'h91, 1'b0);
    exp_q.push_back(8'h55);
    recv_byte(1'b1, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL abort_pointer_reset: got %h expected %h", got, exp); end
    i2c_stop();
  endtask

  task automatic test_abort_rstart();
    i2c_start();
    send_checked(8'h90, 1'b0);
    send_checked(8'h03, 1'b0);
    send_checked(8'h3C, 1'b0);
    i2c_stop();
    repeat (4) @(negedge sys_clk);
    n_checks++;
    if (config_reg !== 8'h3C) begin n_errors++; $display("FAIL rstart_setup_config: got %h expected 3c", config_reg); end
    i2c_start();
    send_checked(8'h90, 1'b0);
    send_checked(8'h03, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_rstart();
    i2c_stop();
    repeat (4) @(negedge sys_clk);
    n_checks++;
    if (config_reg !== 8'h3C) begin n_errors++; $display("FAIL rstart_partial_discard: got %h expected 3c", config_reg); end
    n_checks++;
    if (state !== 4'd0) begin n_errors++; $display("FAIL rstart_state: got %0d expected 0", state); end
  endtask

  initial begin
    test_reset();
    test_ptr_write_read();
    test_addr_mismatch();
    test_config_id();
    test_snapshot();
    test_pointer_wrap();
    test_abort_reset();
    test_abort_rstart();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_temp_sensor_target.md
Name: i2c_temp_sensor_target

Overview:
- I2C target (responder) emulating the ADT7420 temperature sensor register interface.
- Serves as the bench- and board-side counterpart to the team's I2C master, which writes a register pointer and reads the 16-bit temperature.
- Oversamples SCL/SDA on the system clock, decodes START/STOP/address/data, and drives SDA open-drain for ACK and read data.
- Temperature value is supplied on a port, so master read paths can be exercised without silicon.

Parameters:
- TARGET_ADDR, 7'h48, 7-bit I2C address to respond to (A1=A0=0).
- DEVICE_ID, 8'hCB, value returned from register 0x0B.
- CONFIG_RST, 8'h00, reset value of config register 0x03.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- scl_in  in  1  I2C SCL line (asynchronous).
- sda_in  in  1  I2C SDA line (asynchronous).
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- temp_value  in  16  current temperature register value {MSB,LSB}.
- config_reg  out  8  register 0x03 contents.
- busy  out  1  high from address match to STOP/abort.
- addr_hit  out  1  one-cycle pulse on address match.
- State  out  4  FSM state encoding, for debug probes.

Behaviour:
- Reset values: sda_oe=0, busy=0, addr_hit=0, State=IDLE, pointer=8'h00, config_reg=CONFIG_RST.
- Reset is async: mid-transfer assertion releases SDA immediately.
- Input synchronisation:
  - scl_in and sda_in each pass through 2-flop synchronisers.
  - Edge detect uses the synced value vs. its previous value.
  - SCL high and low times must each be >= 4 sys_clk cycles.
- Condition detection:
  - START = synced SDA falls while synced SCL high.
  - STOP = synced SDA rises while synced SCL high.
  - Both are detected in every state and take priority over bit processing.
- Timing: sample bits on the SCL rising-edge detect; update sda_oe on the cycle after the SCL falling-edge detect.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE: START -> ADDR, bit counter cleared.
- ADDR: shift 8 bits MSB first.
  - After the 8th bit, if addr[7:1]==TARGET_ADDR: addr_hit pulse, busy=1, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP; no ACK.
- ADDR_ACK: sda_oe=1 from the falling edge after bit 8 until the falling edge after bit 9.
  - R/W=0 -> WR_PTR.
  - R/W=1 -> take temp snapshot, load the byte at pointer, then RD_DATA.
- WR_PTR: first written byte goes to pointer; ACK via WR_ACK; then WR_DATA.
- WR_DATA: each byte writes to register[pointer] and pointer increments.
  - Only 0x03 is writable; writes to other addresses are ACKed and discarded.
  - Every write byte is ACKed.
- RD_DATA: sda_oe = ~bit, MSB first, 8 bits; after the 8th bit, release SDA and go to RD_ACK.
- RD_ACK: sample master ACK at the 9th rising edge.
  - ACK (0): pointer++, load next byte, back to RD_DATA.
  - NACK (1): WAIT_STOP with SDA released.
- Register map:
  - 0x00 = snapshot[15:8]
  - 0x01 = snapshot[7:0]
  - 0x02 = 8'h00 (status)
  - 0x03 = config_reg
  - 0x0B = DEVICE_ID
  - all other addresses read 8'h00
- Snapshot: 16-bit copy of temp_value, latched at the read address ACK so MSB and LSB are coherent across a burst.
- Pointer: 8 bits, wraps 8'hFF -> 8'h00; retained across transactions.
- Repeated START (any state, including mid-byte) -> ADDR; sda_oe released that cycle. A partially written byte is discarded.
- STOP (any state) -> IDLE; sda_oe=0 and busy=0 the next cycle.
- WAIT_STOP: ignore all bits until STOP (-> IDLE) or START (-> ADDR).

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined: after synchronisation, each line passes through a 3-sample stability filter. The filtered value updates only when 3 consecutive synced samples agree. This adds 3 cycles of latency, and pulses shorter than 3 sys_clk cycles are rejected.
- Undefined: the synchronised values are used directly.

Test Plan:
- Pointer write then read:
  - Stimulus: START, 0x90, ACK, 0x00, ACK, Sr, 0x91; temp_value=16'h0C80; master ACKs byte 1 and NACKs byte 2; STOP.
  - Response: target ACKs all three, returns 0x0C then 0x80, busy low after STOP.
- Address mismatch:
  - Stimulus: START, 0x92, then 2 bytes, STOP.
  - Response: sda_oe stays 0 throughout, addr_hit never pulses, State returns to IDLE.
- Config write and ID read:
  - Stimulus: write ptr 0x03 + data 0xA5, STOP; then ptr 0x0B and read 1 byte.
  - Response: config_reg=8'hA5; read returns 8'hCB.
- Snapshot coherency:
  - Stimulus: read from ptr 0x00; temp_value changes from 16'h1234 to 16'h5678 between MSB and LSB.
  - Response: read returns 0x12 then 0x34.
- Pointer wrap:
  - Stimulus: set ptr 0xFF; read 2 bytes with ACK.
  - Response: 0x00 (from 0xFF), then snapshot MSB from 0x00.
- Abort handling:
  - Stimulus: reset_n low mid read byte (sda_oe=1).
  - Response: sda_oe=0 in the same cycle, pointer=0, State=IDLE.
  - Stimulus: repeated START mid write byte.
  - Response: that byte is discarded, config_reg unchanged.
